// File: rtl/dg0045_pkg.sv
// Shared types and constants for the dg0045 program-ROM server.
package dg0045_pkg;
    localparam int PC_W   = 10;
    localparam int HL_W   = 5;
    localparam int DATA_W = 8;

    localparam logic [DATA_W-1:0] NOP = 8'h00;

    typedef enum logic [2:0] {
        SEL_LO,
        SMP_LO,
        SEL_HI,
        SMP_HI,
        READ,
        LOAD
    } fetch_state_e;
endpackage

// File: rtl/dg0045_prog_ram.sv
// Program store: synchronous write, combinational read, out-of-range reads return NOP.
module dg0045_prog_ram
    import dg0045_pkg::*;
#(
    parameter int DEPTH = 1024
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [PC_W-1:0]   wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [PC_W-1:0]   rd_addr,
    output logic [DATA_W-1:0] rd_data
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic              wr_hit;
    logic              rd_hit;

    // Full-width range checks so addresses past DEPTH never alias onto low words.
    assign wr_hit  = int'(wr_addr) < DEPTH;
    assign rd_hit  = int'(rd_addr) < DEPTH;
    assign rd_data = rd_hit ? mem[rd_addr[AW-1:0]] : NOP;

    always_ff @(posedge clk) begin
        if (wr_en && wr_hit) begin
            mem[wr_addr[AW-1:0]] <= wr_data;
        end
    end
endmodule

// File: rtl/dg0045_rom_server.sv
// Serves instruction bytes to a CPU with a 5-bit multiplexed program counter,
// and lets a loader rewrite the program store while fetching is halted.
module dg0045_rom_server
    import dg0045_pkg::*;
#(
    parameter int DEPTH  = 1024,
    parameter int SETTLE = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [HL_W-1:0]   pc_hl,
    output logic              pc_mux,
    output logic [DATA_W-1:0] rom_data,
    output logic [PC_W-1:0]   addr_out,
    output logic              addr_strobe,
    input  logic              ld_en,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [PC_W-1:0]   ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output fetch_state_e      dbg_state
);
    localparam logic [1:0] SETTLE_LAST = 2'(SETTLE - 1);

    fetch_state_e      state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [HL_W-1:0]   lo_q, lo_d;
    logic [HL_W-1:0]   hi_q, hi_d;
    logic [PC_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0] rom_q, rom_d;
    logic              strobe_q, strobe_d;
    logic              mux_q, mux_d;
    logic              wr_en;
    logic [DATA_W-1:0] rd_data;

    // Loader handshake: a write is taken on a clock with ld_valid && ld_ready while the
    // FSM sits in LOAD. LOAD is entered one clock after ld_en rises, so the loader holds
    // ld_valid low for that first clock; ld_valid with ld_en low is ignored.
    assign ld_ready = ld_en;
    assign wr_en    = (state_q == LOAD) && ld_en && ld_valid;

    dg0045_prog_ram #(.DEPTH(DEPTH)) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (ld_addr),
        .wr_data (ld_data),
        .rd_addr ({hi_q, lo_q}),
        .rd_data (rd_data)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        lo_d     = lo_q;
        hi_d     = hi_q;
        addr_d   = addr_q;
        rom_d    = rom_q;
        strobe_d = 1'b0;
        if (ld_en) begin
            state_d = LOAD;
            cnt_d   = '0;
            rom_d   = NOP;
        end else begin
            case (state_q)
                SEL_LO: begin
                    if (cnt_q == SETTLE_LAST) begin
                        cnt_d   = '0;
                        state_d = SMP_LO;
                    end else begin
                        cnt_d = cnt_q + 2'd1;
                    end
                end
                SMP_LO: begin
                    lo_d    = pc_hl;
                    state_d = SEL_HI;
                end
                SEL_HI: begin
                    if (cnt_q == SETTLE_LAST) begin
                        cnt_d   = '0;
                        state_d = SMP_HI;
                    end else begin
                        cnt_d = cnt_q + 2'd1;
                    end
                end
                SMP_HI: begin
                    hi_d    = pc_hl;
                    state_d = READ;
                end
                READ: begin
                    addr_d   = {hi_q, lo_q};
                    rom_d    = rd_data;
                    strobe_d = 1'b1;
                    state_d  = SEL_LO;
                end
                LOAD: begin
                    cnt_d   = '0;
                    state_d = SEL_LO;
                end
                default: begin
                    cnt_d   = '0;
                    state_d = SEL_LO;
                end
            endcase
        end
        // pc_mux is registered from the next state so it matches the state it is held in.
        mux_d = (state_d == SEL_HI) || (state_d == SMP_HI);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= SEL_LO;
            cnt_q    <= '0;
            lo_q     <= '0;
            hi_q     <= '0;
            addr_q   <= '0;
            rom_q    <= NOP;
            strobe_q <= 1'b0;
            mux_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            lo_q     <= lo_d;
            hi_q     <= hi_d;
            addr_q   <= addr_d;
            rom_q    <= rom_d;
            strobe_q <= strobe_d;
            mux_q    <= mux_d;
        end
    end

    assign pc_mux      = mux_q;
    assign rom_data    = rom_q;
    assign addr_out    = addr_q;
    assign addr_strobe = strobe_q;
    assign dbg_state   = state_q;
endmodule

// File: tb/tb_dg0045_rom_server.sv
// Bench for dg0045_rom_server: default instance (A) and a DEPTH=64, SETTLE=3 instance (B).
module tb_dg0045_rom_server;
    import dg0045_pkg::*;

    localparam int DEPTH_B = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n_a, ld_en_a, ld_valid_a, pc_mux_a, strobe_a, ld_ready_a;
    logic [9:0]   pc_a, ld_addr_a, addr_out_a;
    logic [7:0]   ld_data_a, rom_data_a;
    logic [4:0]   pc_hl_a;
    fetch_state_e state_a;

    logic         rst_n_b, ld_en_b, ld_valid_b, pc_mux_b, strobe_b, ld_ready_b;
    logic [9:0]   pc_b, ld_addr_b, addr_out_b;
    logic [7:0]   ld_data_b, rom_data_b;
    logic [4:0]   pc_hl_b;
    fetch_state_e state_b;

    // CPU model: presents the half of its PC selected by pc_mux.
    assign pc_hl_a = pc_mux_a ? pc_a[9:5] : pc_a[4:0];
    assign pc_hl_b = pc_mux_b ? pc_b[9:5] : pc_b[4:0];

    dg0045_rom_server u_dut_a (
        .clk(clk), .rst_n(rst_n_a), .pc_hl(pc_hl_a), .pc_mux(pc_mux_a),
        .rom_data(rom_data_a), .addr_out(addr_out_a), .addr_strobe(strobe_a),
        .ld_en(ld_en_a), .ld_valid(ld_valid_a), .ld_ready(ld_ready_a),
        .ld_addr(ld_addr_a), .ld_data(ld_data_a), .dbg_state(state_a)
    );

    dg0045_rom_server #(.DEPTH(DEPTH_B), .SETTLE(3)) u_dut_b (
        .clk(clk), .rst_n(rst_n_b), .pc_hl(pc_hl_b), .pc_mux(pc_mux_b),
        .rom_data(rom_data_b), .addr_out(addr_out_b), .addr_strobe(strobe_b),
        .ld_en(ld_en_b), .ld_valid(ld_valid_b), .ld_ready(ld_ready_b),
        .ld_addr(ld_addr_b), .ld_data(ld_data_b), .dbg_state(state_b)
    );

    // Reference program stores over the full 10-bit PC space.
    logic [7:0]  mem_a [1024];
    logic [7:0]  mem_b [1024];
    logic [17:0] exp_q [$];
    int checks = 0;
    int errors = 0;

    function automatic logic [7:0] ref_b(input logic [9:0] a);
        return (int'(a) < DEPTH_B) ? mem_b[a] : 8'h00;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_strobe(input bit sel, input int budget, output int cycles);
        cycles = 0;
        do begin
            tick();
            cycles++;
        end while (!(sel ? strobe_b : strobe_a) && cycles <= budget);
    endtask

    task automatic load_write(input bit sel, input logic [9:0] a, input logic [7:0] d);
        int gap;
        gap = $urandom_range(0, 1);
        for (int g = 0; g < gap; g++) begin
            if (sel) ld_addr_b = 10'($urandom); else ld_addr_a = 10'($urandom);
            tick();
        end
        if (sel) begin
            ld_addr_b = a; ld_data_b = d; ld_valid_b = 1'b1;
        end else begin
            ld_addr_a = a; ld_data_a = d; ld_valid_a = 1'b1;
        end
        tick();
        ld_valid_a = 1'b0;
        ld_valid_b = 1'b0;
        if (sel) begin
            if (int'(a) < DEPTH_B) mem_b[a] = d;
        end else begin
            mem_a[a] = d;
        end
    endtask

    initial begin
        int n;
        logic [9:0] p1, p2, a;
        logic [17:0] e;

        rst_n_a = 1'b0; ld_en_a = 1'b0; ld_valid_a = 1'b0; ld_addr_a = '0; ld_data_a = '0; pc_a = '0;
        rst_n_b = 1'b0; ld_en_b = 1'b0; ld_valid_b = 1'b0; ld_addr_b = '0; ld_data_b = '0; pc_b = '0;
        repeat (3) tick();

        check("a_rst_pc_mux", pc_mux_a, 0);
        check("a_rst_rom_data", rom_data_a, 0);
        check("a_rst_addr_out", addr_out_a, 0);
        check("a_rst_strobe", strobe_a, 0);
        check("a_rst_ld_ready", ld_ready_a, 0);

        // Load the whole store with random bytes, then the two directed words.
        rst_n_a = 1'b1;
        ld_en_a = 1'b1;
        tick();
        check("a_ld_ready", ld_ready_a, 1);
        check("a_state_load", 32'(state_a), 32'(LOAD));
        for (int i = 0; i < 1024; i++) load_write(1'b0, 10'(i), 8'($urandom));
        load_write(1'b0, 10'h000, 8'h8F);
        load_write(1'b0, 10'h3C5, 8'hC1);
        check("a_load_pc_mux", pc_mux_a, 0);
        check("a_load_rom_data", rom_data_a, 0);
        check("a_load_strobe", strobe_a, 0);

        // Release the loader with PC=0x3C5 presented.
        pc_a = 10'h3C5;
        ld_en_a = 1'b0;
        wait_strobe(1'b0, 20, n);
        check("a_first_fetch_cycles", n, 6);
        check("a_first_addr", addr_out_a, 10'h3C5);
        check("a_first_data", rom_data_a, 8'hC1);

        // One fetch cycle step by step: mux pattern, strobe width, data stability.
        for (int k = 0; k < 4; k++) begin
            tick();
            check("a_mux_pattern", pc_mux_a, (k == 1 || k == 2) ? 1 : 0);
            check("a_strobe_low", strobe_a, 0);
            check("a_data_stable", rom_data_a, 8'hC1);
        end
        tick();
        check("a_period_strobe", strobe_a, 1);

        // Hold PC=0 with stray ld_valid (ld_en low must ignore it).
        pc_a = 10'h000;
        ld_valid_a = 1'b1; ld_addr_a = 10'h000; ld_data_a = 8'h11;
        for (int r = 0; r < 3; r++) begin
            wait_strobe(1'b0, 20, n);
            check("a_hold0_period", n, 5);
            check("a_hold0_addr", addr_out_a, 10'h000);
            check("a_hold0_data", rom_data_a, 8'h8F);
        end
        ld_valid_a = 1'b0;

        // Random fetches against the reference store.
        for (int r = 0; r < 12; r++) begin
            a = 10'($urandom_range(0, 1023));
            pc_a = a;
            exp_q.push_back({a, mem_a[a]});
            wait_strobe(1'b0, 20, n);
            e = exp_q.pop_front();
            check("a_rand_period", n, 5);
            check("a_rand_addr", addr_out_a, e[17:8]);
            check("a_rand_data", rom_data_a, e[7:0]);
        end

        // ld_en raised while in SMP_HI aborts the fetch.
        repeat (3) tick();
        check("a_smp_hi_mux", pc_mux_a, 1);
        ld_en_a = 1'b1;
        tick();
        check("a_abort_state", 32'(state_a), 32'(LOAD));
        check("a_abort_mux", pc_mux_a, 0);
        check("a_abort_data", rom_data_a, 0);
        check("a_abort_strobe", strobe_a, 0);
        check("a_abort_addr_kept", addr_out_a, a);
        tick();
        check("a_abort_strobe2", strobe_a, 0);
        ld_en_a = 1'b0;
        pc_a = 10'h3C5;
        wait_strobe(1'b0, 20, n);
        check("a_resume_cycles", n, 6);
        check("a_resume_data", rom_data_a, 8'hC1);

        // Asynchronous reset during SEL_HI.
        repeat (2) tick();
        check("a_sel_hi_mux", pc_mux_a, 1);
        #1 rst_n_a = 1'b0;
        #1;
        check("a_async_mux", pc_mux_a, 0);
        check("a_async_data", rom_data_a, 0);
        check("a_async_addr", addr_out_a, 0);
        repeat (2) tick();
        pc_a = 10'h000;
        rst_n_a = 1'b1;
        wait_strobe(1'b0, 20, n);
        check("a_post_rst_cycles", n, 5);
        check("a_post_rst_data", rom_data_a, 8'h8F);

        // Instance B: DEPTH=64, SETTLE=3.
        pc_b = 10'h040;
        rst_n_b = 1'b1;
        wait_strobe(1'b1, 30, n);
        check("b_first_cycles", n, 9);
        check("b_oob_addr", addr_out_b, 10'h040);
        check("b_oob_data", rom_data_b, 0);

        ld_en_b = 1'b1;
        tick();
        for (int i = 0; i < DEPTH_B; i++) load_write(1'b1, 10'(i), 8'($urandom));
        load_write(1'b1, 10'h010, 8'h5A);
        load_write(1'b1, 10'h050, 8'hEE);
        load_write(1'b1, 10'h03F, 8'h77);
        ld_en_b = 1'b0;
        pc_b = 10'h010;
        wait_strobe(1'b1, 30, n);
        check("b_reload_cycles", n, 10);
        check("b_no_alias_data", rom_data_b, 8'h5A);
        pc_b = 10'h050;
        wait_strobe(1'b1, 30, n);
        check("b_period", n, 9);
        check("b_dropped_data", rom_data_b, 0);
        pc_b = 10'h03F;
        wait_strobe(1'b1, 30, n);
        check("b_last_word", rom_data_b, 8'h77);
        pc_b = 10'h040;
        wait_strobe(1'b1, 30, n);
        check("b_first_oob", rom_data_b, 0);

        // PC changes between halves: lo from the SMP_LO edge, hi from the SMP_HI edge.
        for (int r = 0; r < 6; r++) begin
            pc_b = 10'($urandom);
            tick();
            p1 = 10'($urandom_range(0, 127));
            pc_b = p1;
            repeat (3) tick();
            p2 = 10'($urandom_range(0, 127));
            pc_b = p2;
            repeat (4) tick();
            check("b_mid_no_strobe", strobe_b, 0);
            pc_b = 10'($urandom);
            tick();
            a = {p2[9:5], p1[4:0]};
            check("b_mid_strobe", strobe_b, 1);
            check("b_mid_addr", addr_out_b, a);
            check("b_mid_data", rom_data_b, ref_b(a));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
